// File: rtl/aes_core.sv
// aes_core: iterative AES block cipher. It encrypts (FIPS-197 Cipher) or
// decrypts (FIPS-197 InvCipher) one block for AES-128/192/256, then stops.
// It latches its inputs once after reset, expands the key one word per
// cycle, and then runs one round per cycle. The result stays on the output
// until the next reset.
//
// Ports
//   clk        in   1    rising-edge clock
//   rst        in   1    asynchronous active-high reset
//   enc        in   1    1 = encrypt, 0 = decrypt
//   aes_len    in   2    01 = AES-128, 10 = AES-192, 11 = AES-256 (00 -> AES-128)
//   key        in   256  key, left-justified, byte 0 = key[255:248]
//   plaintext  in   128  input block, byte 0 = [127:120]
//   ciphertext out  128  result block (0 until valid)
//   valid      out  1    result available (held until reset)
module aes_core (
  input  logic         clk,
  input  logic         rst,
  input  logic         enc,
  input  logic [1:0]   aes_len,
  input  logic [255:0] key,
  input  logic [127:0] plaintext,
  output logic [127:0] ciphertext,
  output logic         valid
);

  typedef enum logic [2:0] {LOAD, KEXP, INIT, ROUND, DONE} state_t;

  // control registers (reset)
  state_t       state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [5:0]   idx_q, idx_d;
  logic [2:0]   kcnt_q, kcnt_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [127:0] ct_q, ct_d;
  logic         vld_q, vld_d;

  // datapath registers (no reset needed)
  logic         enc_q;
  logic [5:0]   nk_q;
  logic [3:0]   nr_q;
  logic [31:0]  w_q [0:59];
  logic [127:0] st_q, st_d;

  logic [5:0]   nk_in;
  logic [3:0]   nr_in;
  logic [3:0]   rk_sel;
  logic [5:0]   rk_base;
  logic [127:0] rk;
  logic [31:0]  w_prev, w_old, w_tmp, w_new;
  logic [127:0] sr, rnd_out;
  logic         last_rnd;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 = a^(2+4+...+128); 0 maps to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    o = '0;
    for (int n = 0; n < 16; n++)
      o[127-8*n -: 8] = inv ? inv_sbox(s[127-8*n -: 8]) : sbox(s[127-8*n -: 8]);
    return o;
  endfunction

  // Byte (row r, column c) sits at index 4c+r.
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    int src;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c - r + 4) % 4 : (c + r) % 4;
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*src+r) -: 8];
      end
    return o;
  endfunction

  // Circulant matrix rows: {02,03,01,01} forward, {0e,0b,0d,09} inverse.
  function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [31:0]  kc;
    logic [7:0]   b;
    o  = '0;
    kc = inv ? 32'h0e0b0d09 : 32'h02030101;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        b = 8'h00;
        for (int j = 0; j < 4; j++)
          b = b ^ gmul(s[127-8*(4*c+(r+j)%4) -: 8], kc[31-8*j -: 8]);
        o[127-8*(4*c+r) -: 8] = b;
      end
    return o;
  endfunction

  always_comb begin
    case (aes_len)
      2'b10:   begin nk_in = 6'd6; nr_in = 4'd12; end
      2'b11:   begin nk_in = 6'd8; nr_in = 4'd14; end
      default: begin nk_in = 6'd4; nr_in = 4'd10; end
    endcase
  end

  // Round-key selection. rnd_q is 0 in INIT, so INIT picks key 0 (encrypt)
  // or key Nr (decrypt) through the same path the rounds use.
  always_comb begin
    rk_sel  = enc_q ? rnd_q : nr_q - rnd_q;
    rk_base = {rk_sel, 2'b00};
    rk      = {w_q[rk_base], w_q[rk_base + 6'd1], w_q[rk_base + 6'd2], w_q[rk_base + 6'd3]};
  end

  // Key schedule step. kcnt_q tracks i mod Nk without a divider.
  always_comb begin
    w_prev = w_q[idx_q - 6'd1];
    w_old  = w_q[idx_q - nk_q];
    if (kcnt_q == 3'd0)
      w_tmp = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {rcon_q, 24'h000000};
    else if (nk_q == 6'd8 && kcnt_q == 3'd4)
      w_tmp = sub_word(w_prev);
    else
      w_tmp = w_prev;
    w_new = w_old ^ w_tmp;
  end

  // One round. SubBytes and ShiftRows commute, so both directions share the
  // substitute-then-permute order. Decrypt adds the key before InvMixColumns.
  always_comb begin
    last_rnd = (rnd_q == nr_q);
    sr       = shift_rows(sub_bytes(st_q, !enc_q), !enc_q);
    if (enc_q)
      rnd_out = (last_rnd ? sr : mix_columns(sr, 1'b0)) ^ rk;
    else
      rnd_out = last_rnd ? (sr ^ rk) : mix_columns(sr ^ rk, 1'b1);
  end

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    idx_d   = idx_q;
    kcnt_d  = kcnt_q;
    rcon_d  = rcon_q;
    ct_d    = ct_q;
    vld_d   = vld_q;
    st_d    = st_q;
    case (state_q)
      LOAD: begin
        state_d = KEXP;
        rnd_d   = 4'd0;
        idx_d   = nk_in;
        kcnt_d  = 3'd0;
        rcon_d  = 8'h01;
        ct_d    = '0;
        vld_d   = 1'b0;
        st_d    = plaintext;
      end
      KEXP: begin
        idx_d  = idx_q + 6'd1;
        kcnt_d = ({3'b000, kcnt_q} == nk_q - 6'd1) ? 3'd0 : kcnt_q + 3'd1;
        if (kcnt_q == 3'd0) rcon_d = xt(rcon_q);
        // Last word index is 4*Nr+3.
        if (idx_q == {nr_q, 2'b11}) state_d = INIT;
      end
      INIT: begin
        st_d    = st_q ^ rk;
        rnd_d   = 4'd1;
        state_d = ROUND;
      end
      ROUND: begin
        st_d = rnd_out;
        if (last_rnd) begin
          ct_d    = rnd_out;
          vld_d   = 1'b1;
          state_d = DONE;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      DONE: begin
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
      rnd_q   <= 4'd0;
      idx_q   <= 6'd0;
      kcnt_q  <= 3'd0;
      rcon_q  <= 8'h01;
      ct_q    <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      idx_q   <= idx_d;
      kcnt_q  <= kcnt_d;
      rcon_q  <= rcon_d;
      ct_q    <= ct_d;
      vld_q   <= vld_d;
    end
  end

  // All eight key words are stored on LOAD. For shorter keys the extra
  // words are overwritten by the schedule before anything reads them.
  always_ff @(posedge clk) begin
    st_q <= st_d;
    if (state_q == LOAD) begin
      enc_q  <= enc;
      nk_q   <= nk_in;
      nr_q   <= nr_in;
      w_q[0] <= key[255:224];
      w_q[1] <= key[223:192];
      w_q[2] <= key[191:160];
      w_q[3] <= key[159:128];
      w_q[4] <= key[127:96];
      w_q[5] <= key[95:64];
      w_q[6] <= key[63:32];
      w_q[7] <= key[31:0];
    end else if (state_q == KEXP) begin
      w_q[idx_q] <= w_new;
    end
  end

  assign ciphertext = ct_q;
  assign valid      = vld_q;

endmodule

// File: tb/tb_aes_core.sv
// tb_aes_core: self-checking bench for aes_core. It runs known-answer
// vectors with latency checks, checks that the result is held, applies
// reset mid-operation and in DONE, and compares random operations with a
// byte-matrix AES reference model.
module tb_aes_core;

  logic         clk;
  logic         rst;
  logic         enc;
  logic [1:0]   aes_len;
  logic [255:0] key;
  logic [127:0] plaintext;
  logic [127:0] ciphertext;
  logic         valid;

  int checks = 0;
  int errors = 0;

  aes_core dut (
    .clk        (clk),
    .rst        (rst),
    .enc        (enc),
    .aes_len    (aes_len),
    .key        (key),
    .plaintext  (plaintext),
    .ciphertext (ciphertext),
    .valid      (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic         e;
    logic [1:0]   l;
    logic [255:0] k;
    logic [127:0] p;
    logic [127:0] x;
    logic [7:0]   lat;
  } vec_t;

  vec_t vt [7];

  // ---------------- reference model ----------------
  logic [7:0]  sb  [256];
  logic [7:0]  isb [256];
  logic [7:0]  ms  [4][4];
  logic [31:0] mw  [60];

  // Carry-less product, then reduction modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul_ref(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--)
      if (p[i]) p = p ^ (15'h11b << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gf_mul_ref(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb[x]  = s;
      isb[s] = 8'(x);
    end
  endtask

  function automatic logic [31:0] sub_word_ref(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic add_rk(input int rd);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        ms[r][c] = ms[r][c] ^ mw[4*rd+c][31-8*r -: 8];
  endtask

  task automatic sub_ref(input bit inv);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        ms[r][c] = inv ? isb[ms[r][c]] : sb[ms[r][c]];
  endtask

  task automatic shift_ref(input bit inv);
    logic [7:0] row [4];
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) row[c] = ms[r][c];
      for (int c = 0; c < 4; c++)
        if (!inv) ms[r][c] = row[(c+r)%4];
        else      ms[r][(c+r)%4] = row[c];
    end
  endtask

  task automatic mix_ref(input bit inv);
    logic [7:0] a [4];
    logic [7:0] m [4];
    if (!inv) begin m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01; end
    else      begin m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09; end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = ms[r][c];
      for (int r = 0; r < 4; r++)
        ms[r][c] = gf_mul_ref(a[r], m[0]) ^ gf_mul_ref(a[(r+1)%4], m[1]) ^
                   gf_mul_ref(a[(r+2)%4], m[2]) ^ gf_mul_ref(a[(r+3)%4], m[3]);
    end
  endtask

  task automatic aes_ref(input logic e, input logic [1:0] l, input logic [255:0] k,
                         input logic [127:0] p, output logic [127:0] ct, output int lat);
    int nk, nr, nw;
    logic [31:0] t;
    logic [7:0]  rc;
    case (l)
      2'b10:   begin nk = 6; nr = 12; end
      2'b11:   begin nk = 8; nr = 14; end
      default: begin nk = 4; nr = 10; end
    endcase
    nw = 4 * (nr + 1);
    for (int i = 0; i < nk; i++) mw[i] = k[255-32*i -: 32];
    for (int i = nk; i < nw; i++) begin
      t = mw[i-1];
      if (i % nk == 0) begin
        t  = sub_word_ref({t[23:0], t[31:24]});
        rc = 8'h01;
        for (int j = 1; j < i / nk; j++) rc = gf_mul_ref(rc, 8'h02);
        t[31:24] = t[31:24] ^ rc;
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word_ref(t);
      end
      mw[i] = mw[i-nk] ^ t;
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        ms[r][c] = p[127-8*(r+4*c) -: 8];
    if (e) begin
      add_rk(0);
      for (int rd = 1; rd < nr; rd++) begin
        sub_ref(0); shift_ref(0); mix_ref(0); add_rk(rd);
      end
      sub_ref(0); shift_ref(0); add_rk(nr);
    end else begin
      add_rk(nr);
      for (int rd = nr - 1; rd >= 1; rd--) begin
        shift_ref(1); sub_ref(1); add_rk(rd); mix_ref(1);
      end
      shift_ref(1); sub_ref(1); add_rk(0);
    end
    ct = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        ct[127-8*(r+4*c) -: 8] = ms[r][c];
    lat = 1 + (nw - nk) + 1 + nr;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic apply(input logic e, input logic [1:0] l, input logic [255:0] k,
                       input logic [127:0] p);
    enc = e; aes_len = l; key = k; plaintext = p;
  endtask

  // Counts rising edges after reset release until valid. Inputs are
  // scrambled after the latch edge; the DUT must ignore them.
  task automatic wait_valid(output int edges);
    bit found;
    found = 0;
    edges = -1;
    for (int n = 1; n <= 200; n++) begin
      if (!found) begin
        @(posedge clk);
        #1;
        if (n == 1)
          apply(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                {$urandom, $urandom, $urandom, $urandom});
        if (valid) begin
          found = 1;
          edges = n;
        end
      end
    end
  endtask

  task automatic run_op(input logic e, input logic [1:0] l, input logic [255:0] k,
                        input logic [127:0] p, output logic [127:0] ct, output int edges);
    @(negedge clk);
    rst = 1'b1;
    apply(e, l, k, p);
    @(negedge clk);
    rst = 1'b0;
    wait_valid(edges);
    ct = ciphertext;
  endtask

  localparam logic [255:0] K256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;

  initial begin
    logic [127:0] ct;
    logic [127:0] exp_ct;
    logic [127:0] first_ct;
    int edges;
    int exp_lat;
    int bad;
    logic re;
    logic [1:0] rl;
    logic [255:0] rk;
    logic [127:0] rp;

    rst = 1'b0;
    apply(1'b0, 2'b00, '0, '0);
    build_sbox();

    vt[0] = '{1'b0, 2'b11, K256, 128'h8ea2b7ca516745bfeafc49904b496089, PT, 8'd68};
    vt[1] = '{1'b0, 2'b01, {128'h000102030405060708090a0b0c0d0e0f, 128'hfedcba98765432100f1e2d3c4b5a6978},
              128'h69c4e0d86a7b0430d8cdb78070b4c55a, PT, 8'd52};
    vt[2] = '{1'b0, 2'b10, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0123456789abcdef},
              128'hdda97ca4864cdfe06eaf70a0ec0d7191, PT, 8'd60};
    vt[3] = '{1'b1, 2'b01, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
              128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32, 8'd52};
    vt[4] = '{1'b1, 2'b11, K256, PT, 128'h8ea2b7ca516745bfeafc49904b496089, 8'd68};
    vt[5] = '{1'b1, 2'b00, {128'h000102030405060708090a0b0c0d0e0f, 128'h55aa55aa55aa55aa55aa55aa55aa55aa},
              PT, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 8'd52};
    vt[6] = '{1'b1, 2'b10, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
              PT, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, 8'd60};

    // asynchronous reset before any clock edge
    #1 rst = 1'b1;
    #2;
    chk("reset_valid", 128'(valid), 128'd0);
    chk("reset_ct", ciphertext, 128'd0);

    // known-answer vectors
    for (int i = 0; i < 7; i++) begin
      run_op(vt[i].e, vt[i].l, vt[i].k, vt[i].p, ct, edges);
      chk($sformatf("vec%0d_ct", i), ct, vt[i].x);
      chk_int($sformatf("vec%0d_latency", i), edges, int'(vt[i].lat));
    end

    // result held in DONE for 25 cycles
    run_op(1'b1, 2'b11, K256, PT, first_ct, edges);
    chk("hold_first_ct", first_ct, 128'h8ea2b7ca516745bfeafc49904b496089);
    bad = 0;
    for (int n = 0; n < 25; n++) begin
      @(posedge clk);
      #1;
      if (!valid || ciphertext !== first_ct) bad++;
    end
    chk_int("hold_bad_cycles", bad, 0);

    // reset during ROUND of the AES-256 decrypt, then rerun
    @(negedge clk);
    rst = 1'b1;
    apply(vt[0].e, vt[0].l, vt[0].k, vt[0].p);
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    chk("midrst_valid_before", 128'(valid), 128'd0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", 128'(valid), 128'd0);
    chk("midrst_ct", ciphertext, 128'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_valid(edges);
    chk("midrst_rerun_ct", ciphertext, PT);
    chk_int("midrst_rerun_latency", edges, 68);

    // asynchronous reset out of DONE, between clock edges
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("done_rst_valid", 128'(valid), 128'd0);
    chk("done_rst_ct", ciphertext, 128'd0);

    // random operations against the reference model
    for (int i = 0; i < 8; i++) begin
      re = 1'($urandom_range(0, 1));
      rl = 2'($urandom_range(0, 3));
      rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom, $urandom, $urandom};
      aes_ref(re, rl, rk, rp, exp_ct, exp_lat);
      run_op(re, rl, rk, rp, ct, edges);
      chk($sformatf("rand%0d_ct", i), ct, exp_ct);
      chk_int($sformatf("rand%0d_latency", i), edges, exp_lat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
